// File: rtl/scale_price_engine_pkg.sv
// Shared FSM state encoding and the fixed decimal constants used by the
// scale pricing engine.
package scale_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV_COST,
        DIV_EUR,
        DIV_KG,
        DONE
    } state_t;

    localparam int GRAMS_PER_KG   = 1000;
    localparam int CENTS_PER_EURO = 100;
    localparam int ROUND_HALF     = 500;

endpackage

// File: rtl/scale_price_engine_divider.sv
// Restoring divider, one quotient bit per clock, N iterations per division.
// The first iteration runs on the start cycle itself.
module seq_divider #(
    parameter int N = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done
);
    localparam int CNTW = $clog2(N + 1);

    logic [N-1:0]    rem_src, quo_src, rem_nxt, quo_nxt;
    logic [N:0]      shifted, diff;
    logic [CNTW-1:0] left_q;
    logic            running;

    always_comb begin
        rem_src = start ? '0 : remainder;
        quo_src = start ? dividend : quotient;
        shifted = {rem_src, quo_src[N-1]};
        diff    = shifted - {1'b0, divisor};
        if (shifted >= {1'b0, divisor}) begin
            rem_nxt = diff[N-1:0];
            quo_nxt = {quo_src[N-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[N-1:0];
            quo_nxt = {quo_src[N-2:0], 1'b0};
        end
    end

    // done marks the cycle whose closing edge produces the final result
    assign done = running && (left_q == CNTW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            left_q    <= '0;
            running   <= 1'b0;
        end else if (start) begin
            quotient  <= quo_nxt;
            remainder <= rem_nxt;
            left_q    <= CNTW'(N - 1);
            running   <= 1'b1;
        end else if (running) begin
            quotient  <= quo_nxt;
            remainder <= rem_nxt;
            left_q    <= left_q - CNTW'(1);
            if (left_q == CNTW'(1)) running <= 1'b0;
        end
    end

endmodule

// File: rtl/scale_price_engine.sv
// Weighing-scale pricing: net weight times unit price, rounded to cents, split
// into euros and kilograms, and accumulated into a saturating running total.
module scale_price_engine
    import scale_pkg::*;
#(
    parameter int  W         = 14,
    parameter int  PW        = 14,
    parameter int  TW        = 24,
    parameter int  MAX_ITEMS = 16,
    localparam int QW        = W + PW,
    localparam int CW        = $clog2(MAX_ITEMS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  weight_g_i,
    input  logic [PW-1:0] price_i,
    input  logic          tare_load_i,
    input  logic          start_i,
    output logic          ready_o,
    input  logic          clear_total_i,
    output logic          done_o,
    output logic [QW-1:0] cost_o,
    output logic [QW-1:0] euros_int_o,
    output logic [6:0]    euros_frac_o,
    output logic [W-1:0]  kg_int_o,
    output logic [9:0]    kg_frac_o,
    output logic [W-1:0]  tare_o,
    output logic [TW-1:0] total_o,
    output logic [CW-1:0] item_count_o,
    output logic          ovf_o
);
    localparam int SW  = ((TW > QW) ? TW : QW) + 1;
    localparam int MCW = (PW > 1) ? $clog2(PW) : 1;

    state_t         state;
    logic [W-1:0]   tare_q, net_q, tare_eff;
    logic [PW-1:0]  price_sh;
    logic [MCW-1:0] mul_cnt;
    logic [QW-1:0]  product_q, cost_q, eur_int_q;
    logic [6:0]     eur_frac_q;
    logic           div_go, div_last, accept;
    logic [QW-1:0]  div_dividend, div_divisor, div_quotient, div_remainder;
    logic [SW-1:0]  sum;

    assign tare_o   = tare_q;
    assign ready_o  = rst_n && (state == IDLE) && (item_count_o < CW'(MAX_ITEMS)) && !clear_total_i;
    assign accept   = start_i && ready_o;
    assign tare_eff = tare_load_i ? weight_g_i : tare_q;
    assign sum      = SW'(total_o) + SW'(cost_q);

    always_comb begin
        div_dividend = div_quotient;
        div_divisor  = QW'(CENTS_PER_EURO);
        case (state)
            DIV_COST: begin
                div_dividend = product_q + QW'(ROUND_HALF);
                div_divisor  = QW'(GRAMS_PER_KG);
            end
            DIV_KG: begin
                div_dividend = {{PW{1'b0}}, net_q};
                div_divisor  = QW'(GRAMS_PER_KG);
            end
            default: ;
        endcase
    end

    seq_divider #(.N(QW)) div_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_go),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (div_quotient),
        .remainder (div_remainder),
        .done      (div_last)
    );

    // Each division phase hands its result to the next on the restart cycle,
    // since the shared divider overwrites its outputs from then on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tare_q       <= '0;
            net_q        <= '0;
            price_sh     <= '0;
            mul_cnt      <= '0;
            product_q    <= '0;
            cost_q       <= '0;
            eur_int_q    <= '0;
            eur_frac_q   <= '0;
            div_go       <= 1'b0;
            done_o       <= 1'b0;
            cost_o       <= '0;
            euros_int_o  <= '0;
            euros_frac_o <= '0;
            kg_int_o     <= '0;
            kg_frac_o    <= '0;
            total_o      <= '0;
            item_count_o <= '0;
            ovf_o        <= 1'b0;
        end else begin
            div_go <= 1'b0;
            case (state)
                IDLE: begin
                    if (tare_load_i) tare_q <= weight_g_i;
                    if (clear_total_i) begin
                        total_o      <= '0;
                        item_count_o <= '0;
                        ovf_o        <= 1'b0;
                    end else if (accept) begin
                        net_q     <= (weight_g_i > tare_eff) ? weight_g_i - tare_eff : '0;
                        price_sh  <= price_i;
                        product_q <= '0;
                        mul_cnt   <= MCW'(PW - 1);
                        state     <= MUL;
                    end
                end
                MUL: begin
                    product_q <= {product_q[QW-2:0], 1'b0} + (price_sh[PW-1] ? {{PW{1'b0}}, net_q} : '0);
                    price_sh  <= price_sh << 1;
                    mul_cnt   <= mul_cnt - MCW'(1);
                    if (mul_cnt == '0) begin
                        state  <= DIV_COST;
                        div_go <= 1'b1;
                    end
                end
                DIV_COST: begin
                    if (div_last) begin
                        state  <= DIV_EUR;
                        div_go <= 1'b1;
                    end
                end
                DIV_EUR: begin
                    if (div_go) cost_q <= div_quotient;
                    if (div_last) begin
                        state  <= DIV_KG;
                        div_go <= 1'b1;
                    end
                end
                DIV_KG: begin
                    if (div_go) begin
                        eur_int_q  <= div_quotient;
                        eur_frac_q <= div_remainder[6:0];
                    end
                    if (div_last) state <= DONE;
                end
                DONE: begin
                    // First DONE cycle commits; the second carries the done pulse
                    if (!done_o) begin
                        done_o       <= 1'b1;
                        cost_o       <= cost_q;
                        euros_int_o  <= eur_int_q;
                        euros_frac_o <= eur_frac_q;
                        kg_int_o     <= div_quotient[W-1:0];
                        kg_frac_o    <= div_remainder[9:0];
                        item_count_o <= item_count_o + CW'(1);
                        if (sum > SW'({TW{1'b1}})) begin
                            total_o <= '1;
                            ovf_o   <= 1'b1;
                        end else begin
                            total_o <= sum[TW-1:0];
                        end
                    end else begin
                        done_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
